// File: rtl/data_memory.sv
// Word-organised data RAM for the 16-bit CPU.
// Supports byte and word loads/stores, and a clear sweep that zeroes the array.
// Loads are combinational. Stores and the clear sweep take effect on the rising edge.
module data_memory #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ALU_out,
   input  logic [15:0] Write_Data,
   input  logic        Mem_Read,
   input  logic        Mem_Write,
   input  logic        Byte_Op,
   input  logic        Mem_Clear,
   output logic [15:0] Mem_Out,
   output logic        Mem_Busy,
   output logic        Mem_Err
);

   // state | meaning
   // SWEEP | zeroing mem_q[cnt_q] each edge; core is stalled
   // READY | normal load/store service
   typedef enum logic {SWEEP = 1'b0, READY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [15:0]       mem_q [DEPTH];

   logic [ADDR_W-1:0] idx;
   logic              out_of_range;
   logic              misaligned;
   logic              fault;
   logic [15:0]       rd_word;

   logic              we_lo;
   logic              we_hi;
   logic [ADDR_W-1:0] widx;
   logic [15:0]       wdata;

   assign idx          = ALU_out[ADDR_W:1];
   assign out_of_range = {16'h0000, ALU_out} >= 32'(2 * DEPTH);
   assign misaligned   = !Byte_Op && ALU_out[0];
   assign rd_word      = mem_q[idx];

   // Busy is a pure decode of the state register, so it has no input-to-output path.
   assign Mem_Busy = (state_q == SWEEP);

   // State register and clear counter. Reset restarts the sweep from word 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SWEEP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. Clear is only honoured from READY, so a held level cannot extend a sweep.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         SWEEP: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = READY;
            end
         end
         READY: begin
            if (Mem_Clear) begin
               state_d = SWEEP;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = SWEEP;
            cnt_d   = '0;
         end
      endcase
   end

   // Fault detection and the combinational load path.
   always_comb begin
      fault   = 1'b0;
      Mem_Err = 1'b0;
      Mem_Out = 16'h0000;
      if (state_q == READY) begin
         fault   = (Mem_Read || Mem_Write) && (out_of_range || misaligned);
         Mem_Err = fault;
         if (Mem_Read && !fault) begin
            if (!Byte_Op) begin
               Mem_Out = rd_word;
            end else if (ALU_out[0]) begin
               Mem_Out = {8'h00, rd_word[15:8]};
            end else begin
               Mem_Out = {8'h00, rd_word[7:0]};
            end
         end
      end
   end

   // Write port. The sweep and stores share it, and a clear in READY suppresses a same-cycle store.
   always_comb begin
      we_lo = 1'b0;
      we_hi = 1'b0;
      widx  = idx;
      wdata = Write_Data;
      if (state_q == SWEEP) begin
         we_lo = 1'b1;
         we_hi = 1'b1;
         widx  = cnt_q;
         wdata = 16'h0000;
      end else if (Mem_Write && !Mem_Clear && !fault) begin
         if (Byte_Op) begin
            wdata = {Write_Data[7:0], Write_Data[7:0]};
            we_lo = !ALU_out[0];
            we_hi = ALU_out[0];
         end else begin
            we_lo = 1'b1;
            we_hi = 1'b1;
         end
      end
   end

   // Storage array with per-byte-lane write enables. It has no reset because the sweep clears it.
   always_ff @(posedge clk) begin
      if (we_lo) begin
         mem_q[widx][7:0] <= wdata[7:0];
      end
      if (we_hi) begin
         mem_q[widx][15:8] <= wdata[15:8];
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory. The reference model is a flat byte array plus a sweep countdown.
module tb_data_memory;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;
   localparam int NBYTES = 2 * DEPTH;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] alu = '0;
   logic [15:0] wd  = '0;
   logic        rd  = 1'b0;
   logic        wr  = 1'b0;
   logic        bop = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] mem_out;
   logic        busy;
   logic        err;

   data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .ALU_out(alu), .Write_Data(wd),
      .Mem_Read(rd), .Mem_Write(wr), .Byte_Op(bop), .Mem_Clear(clr),
      .Mem_Out(mem_out), .Mem_Busy(busy), .Mem_Err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] out;
      logic        err;
      logic        busy;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  mb[NBYTES];
   int          sweep_left = 0;
   int          checks = 0;
   int          passed = 0;
   int          cyc = 0;

   task automatic zero_model();
      for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
      sweep_left = DEPTH;
   endtask

   // Drive one cycle of inputs, predict the outputs for this cycle, then apply the edge's effect to the model.
   task automatic step(input logic r, input logic rd_i, input logic wr_i, input logic b_i,
                       input logic c_i, input logic [15:0] a, input logic [15:0] w);
      exp_t e;
      logic f;
      int   ai;
      @(posedge clk);
      #1;
      rst = r; rd = rd_i; wr = wr_i; bop = b_i; clr = c_i; alu = a; wd = w;
      ai = int'(a);
      e.out = 16'h0000; e.err = 1'b0; e.busy = 1'b1; e.cyc = cyc;
      f = 1'b0;
      if (!r && sweep_left == 0) begin
         e.busy = 1'b0;
         f = (rd_i || wr_i) && (ai >= NBYTES || (!b_i && a[0]));
         e.err = f;
         if (rd_i && !f) begin
            if (b_i) e.out = {8'h00, mb[ai]};
            else     e.out = {mb[ai + 1], mb[ai]};
         end
      end
      sb.push_back(e);
      if (r) begin
         zero_model();
      end else if (sweep_left > 0) begin
         sweep_left--;
      end else if (c_i) begin
         zero_model();
      end else if (wr_i && !f) begin
         mb[ai] = w[7:0];
         if (!b_i) mb[ai + 1] = w[15:8];
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   // Random loads/stores, used during sweeps as well to show they are ignored.
   task automatic rand_ops(input int n, input bit allow_clr);
      logic [15:0] a;
      logic        c;
      for (int i = 0; i < n; i++) begin
         a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 80));
         c = allow_clr && ($urandom_range(0, 399) == 0);
         step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              c, a, 16'($urandom_range(0, 65535)));
      end
   endtask

   // Monitor: compare every cycle's outputs against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (mem_out === e.out && err === e.err && busy === e.busy) begin
               passed++;
            end else begin
               $display("FAIL cycle%0d outputs: got out=%h err=%b busy=%b, expected out=%h err=%b busy=%b",
                        e.cyc, mem_out, err, busy, e.out, e.err, e.busy);
            end
         end
      end
   end

   initial begin
      int wait_n;
      zero_model();
      // Reset for two cycles, then the full reset sweep with loads issued throughout.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
      rand_ops(DEPTH, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h01FE, 16'h0000);
      // Word store/load, including a same-cycle read during the store.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h5678);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0000);
      // Byte lanes.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'hABCD);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h00EF);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000);
      // Faults: a misaligned store, an out-of-range load, a non-access, and the boundary word.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0031, 16'hFFFF);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0201, 16'h0000);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h01FE, 16'hBEEF);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h01FF, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000);
      // Clear colliding with a store: the clear wins and the array is zeroed.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h8000);
      rand_ops(DEPTH, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
      // A clear held high through the sweep restarts once on the first READY edge.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0012, 16'h0000);
      // Reset 100 cycles into this sweep, then a full sweep with loads throughout.
      rand_ops(100 - (DEPTH + 1 - DEPTH), 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h1111);
      rand_ops(DEPTH + 4, 1'b0);
      // Mixed random traffic with occasional clears.
      rand_ops(2500, 1'b1);
      idle(2);
      wait_n = 0;
      while (sb.size() > 0 && wait_n < 10) begin
         @(negedge clk);
         wait_n++;
      end
      #1;
      if (sb.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
